// File: rtl/ram_pkg.sv
// Shared widths, RAM command record and RWn encodings for the RAM command master.
package ram_pkg;

   localparam int ADDR_W = 8;
   localparam int DATA_W = 8;

   localparam logic RW_READ  = 1'b1;
   localparam logic RW_WRITE = 1'b0;

   typedef struct packed {
      logic              we;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
   } ram_cmd_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered storage and a head that reads through combinationally.
module sync_fifo #(
   parameter type T         = logic [7:0],
   parameter int  DEPTH     = 2,
   localparam int CNT_W     = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  T                 din,
   input  logic             pop,
   output T                 dout,
   output logic             full,
   output logic             empty,
   output logic [CNT_W-1:0] count
);

   localparam int               PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [PTR_W-1:0] LAST     = PTR_W'(DEPTH - 1);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   T                 mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_push;
   logic             do_pop;

   // explicit wrap keeps the pointers correct for non-power-of-2 depths too
   function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
      return (p == LAST) ? '0 : p + 1'b1;
   endfunction

   assign full    = (count == FULL_CNT);
   assign empty   = (count == '0);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign dout    = mem[rd_ptr];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= din;
            wr_ptr      <= ptr_next(wr_ptr);
         end
         if (do_pop) rd_ptr <= ptr_next(rd_ptr);
         count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
      end
   end

endmodule

// File: rtl/ram_cmd_master.sv
// Queues read/write commands, issues them in order to the 8-bit RAM with a one-cycle strobe,
// and returns read data in order through a credit-limited response FIFO.
module ram_cmd_master
   import ram_pkg::*;
#(
   parameter int CMD_DEPTH = 4,
   parameter int RSP_DEPTH = 2,
   parameter int RD_LAT    = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_we,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [DATA_W-1:0] cmd_wdata,
   output logic              RWn,
   output logic              mem_en,
   output logic [ADDR_W-1:0] raddr,
   output logic [ADDR_W-1:0] waddr,
   output logic [DATA_W-1:0] wdata,
   input  logic [DATA_W-1:0] rdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_data,
   output logic              busy
);

   localparam int            CW       = $clog2(RSP_DEPTH) + 1;
   localparam logic [CW-1:0] CRED_MAX = CW'(RSP_DEPTH);

   ram_cmd_t                   cmd_in;
   ram_cmd_t                   head;
   logic                       cmd_push;
   logic                       cmd_full;
   logic                       cmd_empty;
   logic [$clog2(CMD_DEPTH):0] cmd_count;
   logic                       issue;
   logic                       issue_rd;
   logic                       issue_wr;
   logic                       rd_strobe;
   logic [RD_LAT-1:0]          rd_pipe;
   logic                       rsp_push;
   logic                       rsp_pop;
   logic                       rsp_full;
   logic                       rsp_empty;
   logic [CW-1:0]              rsp_count;
   logic [CW-1:0]              credits;

   assign cmd_in    = '{we: cmd_we, addr: cmd_addr, wdata: cmd_wdata};
   assign cmd_ready = ~cmd_full;
   assign cmd_push  = cmd_valid & cmd_ready;

   sync_fifo #(.T(ram_cmd_t), .DEPTH(CMD_DEPTH)) u_cmd_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (cmd_push),
      .din   (cmd_in),
      .pop   (issue),
      .dout  (head),
      .full  (cmd_full),
      .empty (cmd_empty),
      .count (cmd_count)
   );

   // credits = response slots not yet claimed by an issued read or a buffered response
   always_comb begin
      issue_wr = 1'b0;
      issue_rd = 1'b0;
      if (!cmd_empty) begin
         if (head.we)               issue_wr = 1'b1;
         else if (credits != '0)    issue_rd = 1'b1;
      end
   end

   assign issue = issue_wr | issue_rd;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem_en <= 1'b0;
         RWn    <= RW_READ;
         raddr  <= '0;
         waddr  <= '0;
         wdata  <= '0;
      end else begin
         mem_en <= issue;
         RWn    <= issue_wr ? RW_WRITE : RW_READ;
         if (issue_wr) begin
            waddr <= head.addr;
            wdata <= head.wdata;
         end
         if (issue_rd) raddr <= head.addr;
      end
   end

   assign rd_strobe = mem_en & (RWn == RW_READ);

   // the cast drops the oldest tag once it has left the last stage
   always_ff @(posedge clk or posedge rst) begin
      if (rst) rd_pipe <= '0;
      else     rd_pipe <= RD_LAT'({rd_pipe, rd_strobe});
   end

   assign rsp_push = rd_pipe[RD_LAT-1];

   sync_fifo #(.T(logic [DATA_W-1:0]), .DEPTH(RSP_DEPTH)) u_rsp_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (rsp_push),
      .din   (rdata),
      .pop   (rsp_pop),
      .dout  (rsp_data),
      .full  (rsp_full),
      .empty (rsp_empty),
      .count (rsp_count)
   );

   assign rsp_valid = ~rsp_empty;
   assign rsp_pop   = rsp_valid & rsp_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) credits <= CRED_MAX;
      else     credits <= credits - CW'(issue_rd) + CW'(rsp_pop);
   end

   assign busy = ~cmd_empty | (credits != CRED_MAX);

   a_credit_underflow : assert property (@(posedge clk) disable iff (rst)
      issue_rd |-> (credits != '0));
   a_credit_overflow  : assert property (@(posedge clk) disable iff (rst)
      rsp_pop |-> (credits != CRED_MAX));
   a_rsp_room         : assert property (@(posedge clk) disable iff (rst)
      rsp_push |-> !rsp_full);
   a_slot_total       : assert property (@(posedge clk) disable iff (rst)
      (int'(credits) + int'(rsp_count)) <= RSP_DEPTH);
   a_cmd_count        : assert property (@(posedge clk) disable iff (rst)
      int'(cmd_count) <= CMD_DEPTH);

endmodule
